// File: rtl/inst_fetch_unit_if.sv
// Instruction-fetch bus between the fetch unit and its neighbours.
//   addr           fetch address to the combinational instruction memory
//   instruction    word returned for addr in the same cycle
//   redirect_valid branch/jump taken this cycle
//   redirect_pc    redirect target (byte address)
//   out_valid      prefetch FIFO head valid
//   out_instr      head instruction
//   out_pc         head PC
//   out_ready      decode accepts the head
// master = fetch unit; slave = memory/decode side.
interface inst_fetch_unit_if;
    logic [31:0] addr;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    modport master (
        output addr, out_valid, out_instr, out_pc,
        input  instruction, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  addr, out_valid, out_instr, out_pc,
        output instruction, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word per cycle from a
// combinational instruction memory into a small prefetch FIFO and hands the
// FIFO head to decode over a valid/ready handshake. Supports redirect with
// flush, backpressure and halting after END_ADDR.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   en     start request (IDLE) / return-to-IDLE request (HALT, FIFO empty)
//   bus    inst_fetch_unit_if.master (memory address/data, redirect, output handshake)
//   busy   state is FETCH
//   done   state is HALT and FIFO is empty
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for en; PC parked at RESET_PC, no fetching
// FETCH   | one word pushed per cycle whenever the FIFO can take it
// HALT    | END_ADDR fetched; FIFO drains, wait for redirect or en
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned PC_STEP    = 4,
    parameter logic [31:0] END_ADDR   = 32'h0000_001C,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    inst_fetch_unit_if.master  bus,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [1:0]    state;
    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    logic [31:0] pc_mem    [FIFO_DEPTH];
    logic [31:0] instr_mem [FIFO_DEPTH];

    logic        redirect;
    logic        pop;
    logic        push;
    logic        full;
    logic        last;
    logic [31:0] pc_inc;

    assign redirect = bus.redirect_valid && (state != S_IDLE);
    assign pop      = bus.out_valid && bus.out_ready;
    assign full     = (count == DEPTH_C);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push     = (state == S_FETCH) && !redirect && (!full || pop);
    assign pc_inc   = pc + 32'(PC_STEP);
    // pc_inc wraps modulo 2^32, so a fetch at the top of the address space
    // continues at zero rather than halting.
    assign last     = (pc == END_ADDR) || (pc_inc > END_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else if (redirect) begin
            // Flush wins over the concurrent pop; the word fetched this cycle is dropped.
            state <= S_FETCH;
            pc    <= {bus.redirect_pc[31:2], 2'b00};
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            case (state)
                S_IDLE:  if (en) state <= S_FETCH;
                S_FETCH: if (push && last) state <= S_HALT;
                S_HALT: begin
                    if (en && count == '0) begin
                        state <= S_IDLE;
                        pc    <= RESET_PC;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (push) begin
                pc   <= pc_inc;
                wptr <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wptr]    <= pc;
            instr_mem[wptr] <= bus.instruction;
        end
    end

    assign bus.addr      = pc;
    assign bus.out_valid = (count != '0);
    // Storage is not reset; gate the head so an empty FIFO presents zeros.
    assign bus.out_pc    = bus.out_valid ? pc_mem[rptr]    : '0;
    assign bus.out_instr = bus.out_valid ? instr_mem[rptr] : '0;
    assign busy          = (state == S_FETCH);
    assign done          = (state == S_HALT) && (count == '0);

    assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_C);

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] END_ADDR = 32'h0000_001C;
    localparam int          DEPTH    = 2;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_HALT  = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic busy;
    logic done;

    inst_fetch_unit_if bus();

    inst_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .PC_STEP   (4),
        .END_ADDR  (END_ADDR),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .bus  (bus),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    // Program image; addresses beyond it return defined filler so no X leaks in.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h0022_1820;
            32'h04:  return 32'h00A4_3022;
            32'h08:  return 32'h00C7_2820;
            32'h0C:  return 32'h8C88_0004;
            32'h10:  return 32'hAC89_0008;
            32'h14:  return 32'h10A6_0003;
            32'h18:  return 32'h0109_5020;
            32'h1C:  return 32'h0800_0000;
            default: return a ^ 32'hDEAD_BEEF;
        endcase
    endfunction

    assign bus.instruction = mem_word(bus.addr);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue of {pc, word}, plus PC and mode.
    ent_t        expq[$];
    int          m_state;
    logic [31:0] m_pc;
    bit          popped;

    always @(posedge clk or negedge rst_n) begin : model
        int          occ;
        logic [31:0] nxt;
        if (!rst_n) begin
            expq.delete();
            m_state = M_IDLE;
            m_pc    = RESET_PC;
            popped  = 1'b0;
        end else begin
            occ = expq.size() + (popped ? 1 : 0);
            if (bus.redirect_valid && m_state != M_IDLE) begin
                expq.delete();
                m_pc    = {bus.redirect_pc[31:2], 2'b00};
                m_state = M_FETCH;
            end else if (m_state == M_IDLE) begin
                if (en) m_state = M_FETCH;
            end else if (m_state == M_FETCH) begin
                if (occ < DEPTH || popped) begin
                    expq.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                    nxt = m_pc + 32'd4;
                    if (m_pc == END_ADDR || nxt > END_ADDR) m_state = M_HALT;
                    m_pc = nxt;
                end
            end else begin
                if (en && occ == 0) begin
                    m_state = M_IDLE;
                    m_pc    = RESET_PC;
                end
            end
            popped = 1'b0;
        end
    end

    // Monitor: compares DUT outputs with the model, pops the scoreboard on handshake.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            chk("out_valid", 32'(bus.out_valid), 32'(expq.size() != 0));
            chk("addr", bus.addr, m_pc);
            chk("busy", 32'(busy), 32'(m_state == M_FETCH));
            chk("done", 32'(done), 32'(m_state == M_HALT && expq.size() == 0));
            if (expq.size() != 0) begin
                chk("out_pc", bus.out_pc, expq[0].pc);
                chk("out_instr", bus.out_instr, expq[0].instr);
                if (bus.out_ready) begin
                    void'(expq.pop_front());
                    popped = 1'b1;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int lim, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s: done not seen within %0d cycles, got 0 expected 1", name, lim);
        end
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = tgt;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
    endtask

    task automatic pulse_en();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    initial begin
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        step(3);
        rst_n = 1'b1;
        step(5);

        // Free-run stream to halt, then return to IDLE.
        bus.out_ready = 1'b1;
        pulse_en();
        wait_done(40, "freerun_done");
        pulse_en();
        step(2);

        // Backpressure: FIFO fills, PC holds, then drains without gaps.
        bus.out_ready = 1'b0;
        pulse_en();
        step(6);
        bus.out_ready = 1'b1;
        step(3);

        // Asynchronous reset in the middle of a cycle while fetching.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_addr", bus.addr, RESET_PC);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(5);

        // Redirect while full: old entries are flushed.
        bus.out_ready = 1'b0;
        pulse_en();
        step(5);
        redirect_to(32'h14);
        step(2);
        bus.out_ready = 1'b1;
        wait_done(30, "redirect_full_done");

        // Misaligned redirect with a concurrent pop.
        redirect_to(32'h0);
        step(2);
        redirect_to(32'h0E);
        wait_done(30, "misaligned_done");

        // Wrap from the top of the address space, then back to IDLE.
        redirect_to(32'hFFFF_FFFC);
        wait_done(60, "wrap_done");
        pulse_en();
        step(3);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            bus.out_ready      = ($urandom_range(0, 3) != 0);
            en                 = ($urandom_range(0, 4) == 0);
            bus.redirect_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 2))
                0:       bus.redirect_pc = 32'($urandom_range(0, 40));
                1:       bus.redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: bus.redirect_pc = $urandom;
            endcase
        end
        @(negedge clk);
        en                 = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        step(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
